// File: rtl/wrapper_ctrl_pkg.sv
// Shared definitions for seq_wrapper_ctrl: FSM state encoding, strobe bundle, defaults.
package wrapper_ctrl_pkg;

  localparam int unsigned DEF_NUM_WORDS      = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARMED     = 4'd1,
    LOAD      = 4'd2,
    CHECK     = 4'd3,
    ENG_START = 4'd4,
    WAIT_ENG  = 4'd5,
    SHIFT     = 4'd6,
    WRITE     = 4'd7,
    FINISH    = 4'd8,
    ERR       = 4'd9
  } state_e;

  typedef struct packed {
    logic done;
    logic wr_req;
    logic eng_start;
    logic sr_ld;
    logic r_ld;
    logic sc_ld;
    logic sr_en;
    logic sc_en;
    logic busy;
  } strobes_t;

  // Moore decode of the datapath strobes for a given state.
  function automatic strobes_t decode_strobes(input state_e s);
    strobes_t o;
    o      = '0;
    o.busy = 1'b1;
    case (s)
      IDLE, ARMED, ERR: o.busy = 1'b0;
      LOAD: begin
        o.sr_ld = 1'b1;
        o.r_ld  = 1'b1;
      end
      ENG_START: o.eng_start = 1'b1;
      WAIT_ENG:  o.sc_ld     = 1'b1;
      SHIFT: begin
        o.sr_en = 1'b1;
        o.sc_en = 1'b1;
      end
      WRITE:  o.wr_req = 1'b1;
      FINISH: o.done   = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/eng_watchdog.sv
// Engine wait watchdog: counts WAIT_ENG cycles, flags the cycle on which the limit is reached.
module eng_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic cnt_en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Saturating cycle counter; cleared just before each engine wait begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (cnt_en && (count != CW'(TIMEOUT_CYCLES))) begin
      count <= count + CW'(1);
    end
  end

  // The current wait cycle is the TIMEOUT_CYCLES-th one.
  assign expired_c = cnt_en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/seq_wrapper_ctrl.sv
// Word sequencing controller for the engine wrapper datapath.
// Optional engine watchdog / ERR state enabled by defining ENG_TIMEOUT_EN.
module seq_wrapper_ctrl
  import wrapper_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = DEF_NUM_WORDS,
  parameter int unsigned CNT_W          = $clog2(NUM_WORDS + 1),
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eng_done,
  input  logic             wr_ack,
  output logic             done,
  output logic             wr_req,
  output logic             eng_start,
  output logic             sr_ld,
  output logic             r_ld,
  output logic             sc_ld,
  output logic             sr_en,
  output logic             sc_en,
  output logic             busy,
  output logic [CNT_W-1:0] word_idx,
  output logic             err
);

  state_e   state_q;
  state_e   state_d;
  strobes_t strb_q;
  logic     last_word_c;
  logic     wd_expired_c;

  assign last_word_c = (word_idx == CNT_W'(NUM_WORDS));

`ifdef ENG_TIMEOUT_EN
  eng_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_eng_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == ENG_START),
    .cnt_en   (state_q == WAIT_ENG),
    .expired_c(wd_expired_c)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_expired_c   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completing engine wins over an expiring watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = ARMED;
      ARMED:     if (!start) state_d = LOAD;
      LOAD:      state_d = CHECK;
      CHECK:     state_d = last_word_c ? FINISH : ENG_START;
      ENG_START: state_d = WAIT_ENG;
      WAIT_ENG: begin
        if (eng_done) begin
          state_d = SHIFT;
        end else if (wd_expired_c) begin
          state_d = ERR;
        end
      end
      SHIFT:     state_d = WRITE;
      WRITE:     if (wr_ack) state_d = CHECK;
      FINISH:    state_d = IDLE;
      ERR:       if (start) state_d = ARMED;
      default:   state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each output tracks the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q <= '0;
    end else begin
      strb_q <= decode_strobes(state_d);
    end
  end

  assign done      = strb_q.done;
  assign wr_req    = strb_q.wr_req;
  assign eng_start = strb_q.eng_start;
  assign sr_ld     = strb_q.sr_ld;
  assign r_ld      = strb_q.r_ld;
  assign sc_ld     = strb_q.sc_ld;
  assign sr_en     = strb_q.sr_en;
  assign sc_en     = strb_q.sc_en;
  assign busy      = strb_q.busy;

  // Word index: cleared by LOAD, advanced by SHIFT, never past NUM_WORDS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx <= '0;
    end else if (state_q == LOAD) begin
      word_idx <= '0;
    end else if ((state_q == SHIFT) && !last_word_c) begin
      word_idx <= word_idx + CNT_W'(1);
    end
  end

`ifdef ENG_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (state_d == ERR);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_wrapper_ctrl.sv
// Scoreboard bench for seq_wrapper_ctrl: random responder delays checked against a per-run cost model.
module tb_seq_wrapper_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned T   = 8;
  localparam int unsigned CW0 = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, eng_done = 1'b0, wr_ack = 1'b0;
  logic done, wr_req, eng_start, sr_ld, r_ld, sc_ld, sr_en, sc_en, busy, err;
  logic [CW0-1:0] word_idx;

  logic start1 = 1'b0, eng_done1 = 1'b1, wr_ack1 = 1'b1;
  logic done1, wr_req1, eng_start1, sr_ld1, r_ld1, sc_ld1, sr_en1, sc_en1, busy1, err1;
  logic [0:0] word_idx1;

  always #5 clk = ~clk;

  seq_wrapper_ctrl #(.NUM_WORDS(N), .TIMEOUT_CYCLES(T)) u_dut (
    .clk(clk), .rst(rst), .start(start), .eng_done(eng_done), .wr_ack(wr_ack),
    .done(done), .wr_req(wr_req), .eng_start(eng_start), .sr_ld(sr_ld), .r_ld(r_ld),
    .sc_ld(sc_ld), .sr_en(sr_en), .sc_en(sc_en), .busy(busy), .word_idx(word_idx), .err(err)
  );

  seq_wrapper_ctrl #(.NUM_WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .eng_done(eng_done1), .wr_ack(wr_ack1),
    .done(done1), .wr_req(wr_req1), .eng_start(eng_start1), .sr_ld(sr_ld1), .r_ld(r_ld1),
    .sc_ld(sc_ld1), .sr_en(sr_en1), .sc_en(sc_en1), .busy(busy1), .word_idx(word_idx1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  bit noise_en = 1'b0;

  typedef struct {
    int lat;
    int n_es;
    int n_wr;
    int n_sc;
    int widx;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   eq[$];
  int   aq[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Cost model: LOAD + CHECK/FINISH overhead plus five cycles per word and every wait cycle.
  function automatic exp_t model(input int ev[$], input int av[$], input int nw);
    exp_t x;
    x.lat  = 2;
    x.n_es = nw;
    x.n_wr = 0;
    x.n_sc = 0;
    x.widx = nw;
    for (int k = 0; k < nw; k++) begin
      x.lat  += 5 + ev[k] + av[k];
      x.n_wr += 1 + av[k];
      x.n_sc += 1 + ev[k];
    end
    return x;
  endfunction

  function automatic int outs0();
    return int'({done, wr_req, eng_start, sr_ld, r_ld, sc_ld, sr_en, sc_en, busy, err});
  endfunction

  function automatic int outs1();
    return int'({done1, wr_req1, eng_start1, sr_ld1, r_ld1, sc_ld1, sr_en1, sc_en1, busy1, err1});
  endfunction

  task automatic zeros(output int ev[$], output int av[$]);
    ev.delete();
    av.delete();
    for (int k = 0; k < int'(N); k++) begin
      ev.push_back(0);
      av.push_back(0);
    end
  endtask

  task automatic rand_delays(output int ev[$], output int av[$]);
    ev.delete();
    av.delete();
    for (int k = 0; k < int'(N); k++) begin
      ev.push_back(int'($urandom_range(0, 3)));
      av.push_back(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    start = 1'b1;
    repeat (len) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input int ev[$], input int av[$], input int len);
    foreach (ev[k]) eq.push_back(ev[k]);
    foreach (av[k]) aq.push_back(av[k]);
    exp_q.push_back(model(ev, av, N));
    pulse_start(len);
  endtask

  task automatic wait_drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: run not completed after %0d cycles", name, b);
      exp_q.delete();
      eq.delete();
      aq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Responders: per-word delays for eng_done/wr_ack, random noise where the inputs are ignored.
  initial begin
    int ecur, acur, wc, ac;
    ecur = 0; acur = 0; wc = 0; ac = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_done = 1'b0;
        wr_ack   = 1'b0;
        continue;
      end
      if (eng_start) begin
        ecur = (eq.size() != 0) ? eq.pop_front() : 0;
        wc   = 0;
      end
      if (sr_en) begin
        acur = (aq.size() != 0) ? aq.pop_front() : 0;
        ac   = 0;
      end
      if (sc_ld) begin
        eng_done = (wc >= ecur);
        wc++;
      end else begin
        eng_done = 1'($urandom_range(0, 1));
      end
      if (wr_req) begin
        wr_ack = (ac >= acur);
        ac++;
      end else begin
        wr_ack = 1'($urandom_range(0, 1));
      end
      if (noise_en && busy) start = sc_ld ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor for the NUM_WORDS=4 instance.
  initial begin
    int cyc, load_c, n_es, n_wr, n_sc, n_sh;
    bit p_es, p_ld, p_en, p_dn;
    exp_t x;
    cyc = 0; load_c = 0; n_es = 0; n_wr = 0; n_sc = 0; n_sh = 0;
    p_es = 0; p_ld = 0; p_en = 0; p_dn = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p_es = 0; p_ld = 0; p_en = 0; p_dn = 0;
        continue;
      end
      if (sr_ld) begin
        load_c = cyc; n_es = 0; n_wr = 0; n_sc = 0; n_sh = 0;
      end
      if (sr_ld || r_ld) chk("ld_pair", int'(r_ld), int'(sr_ld));
      if (sr_en || sc_en) chk("en_pair", int'(sc_en), int'(sr_en));
      if (eng_start) chk("eng_start_width", int'(p_es), 0);
      if (sr_ld) chk("ld_width", int'(p_ld), 0);
      if (sr_en) chk("en_width", int'(p_en), 0);
      if (done) chk("done_width", int'(p_dn), 0);
      n_es += int'(eng_start);
      n_wr += int'(wr_req);
      n_sc += int'(sc_ld);
      n_sh += int'(sr_en);
      if (wr_req) chk("word_idx_in_write", int'(word_idx), n_sh);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("done_latency", cyc - load_c, x.lat);
          chk("eng_start_count", n_es, x.n_es);
          chk("wr_req_cycles", n_wr, x.n_wr);
          chk("sc_ld_cycles", n_sc, x.n_sc);
          chk("word_idx_final", int'(word_idx), x.widx);
          chk("err_at_done", int'(err), 0);
        end
      end
      p_es = eng_start; p_ld = sr_ld; p_en = sr_en; p_dn = done;
    end
  end

  // Monitor for the NUM_WORDS=1 instance.
  initial begin
    int cyc, load_c, n_es, n_wr;
    exp_t x;
    cyc = 0; load_c = 0; n_es = 0; n_wr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) continue;
      if (sr_ld1) begin
        load_c = cyc; n_es = 0; n_wr = 0;
      end
      n_es += int'(eng_start1);
      n_wr += int'(wr_req1);
      if (done1) begin
        if (exp1_q.size() == 0) begin
          chk("n1_unexpected_done", 1, 0);
        end else begin
          x = exp1_q.pop_front();
          chk("n1_done_latency", cyc - load_c, x.lat);
          chk("n1_eng_start_count", n_es, x.n_es);
          chk("n1_wr_req_cycles", n_wr, x.n_wr);
          chk("n1_word_idx_final", int'(word_idx1), x.widx);
        end
      end
    end
  end

  initial begin
    int ev[$];
    int av[$];
    int b;
    int z1[$];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs0(), 0);
    chk("reset_word_idx", int'(word_idx), 0);
    chk("reset_outputs_n1", outs1(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    zeros(ev, av);
    issue(ev, av, 2);
    wait_drain("baseline");

    zeros(ev, av);
    ev[1] = 3;
    av[1] = 2;
    issue(ev, av, 2);
    wait_drain("delayed_word1");

    noise_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rand_delays(ev, av);
      ev[0] = 2;
      issue(ev, av, int'($urandom_range(1, 3)));
      wait_drain("ignored_inputs");
    end
    noise_en = 1'b0;

    // Abort a run during the second write and check the asynchronous clear.
    zeros(ev, av);
    av[1] = 6;
    issue(ev, av, 1);
    b = 0;
    while (!(wr_req && word_idx == CW0'(2)) && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("reach_write_word2", int'(b < 200), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", outs0(), 0);
    chk("midrun_reset_word_idx", int'(word_idx), 0);
    exp_q.delete();
    eq.delete();
    aq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after_abort", int'(busy), 0);
    zeros(ev, av);
    issue(ev, av, 2);
    wait_drain("after_abort");

    z1.push_back(0);
    exp1_q.push_back(model(z1, z1, 1));
    @(negedge clk);
    start1 = 1'b1;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    b = 0;
    while (exp1_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("n1_run_completed", int'(exp1_q.size()), 0);

    for (int r = 0; r < 6; r++) begin
      noise_en = (r % 2) == 1;
      rand_delays(ev, av);
      issue(ev, av, int'($urandom_range(1, 3)));
      wait_drain("random_run");
    end
    noise_en = 1'b0;

`ifdef ENG_TIMEOUT_EN
    begin
      int nsc;
      nsc = 0;
      zeros(ev, av);
      ev[0] = 1000;
      foreach (ev[k]) eq.push_back(ev[k]);
      foreach (av[k]) aq.push_back(av[k]);
      pulse_start(1);
      b = 0;
      while (!err && b < 200) begin
        @(negedge clk);
        if (sc_ld) nsc++;
        b++;
      end
      chk("timeout_err", int'(err), 1);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_wait_len", nsc, int'(T));
      eq.delete();
      aq.delete();
      repeat (3) @(negedge clk);
      chk("err_held", int'(err), 1);
      chk("err_no_done", int'(done), 0);
      zeros(ev, av);
      issue(ev, av, 1);
      chk("err_cleared", int'(err), 0);
      wait_drain("after_err");
      zeros(ev, av);
      ev[0] = int'(T) - 1;
      issue(ev, av, 1);
      wait_drain("limit_cycle");
      chk("limit_cycle_no_err", int'(err), 0);
    end
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", int'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
